// File: rtl/deserializer.sv
// Serial-to-parallel stage: packs channel bits MSB-first into words and
// queues them in a small FIFO drained by a valid/ready handshake.
module deserializer #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  serial_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
);

    // state | meaning
    // IDLE  | no valid bits on serial_in; shift register and bit counter clear
    // SHIFT | sampling one bit per clk, pushing each completed word

    localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] shift_reg, shift_nxt;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
    logic                  push;
    logic [WORD_WIDTH-1:0] push_word;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           fifo_cnt;
    logic                  full, pop, push_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // IDLE holds a clear shift register and counter, so the first bit takes
    // the same path as any other and lands as the MSB with no extra latency.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        push        = 1'b0;
        push_word   = {shift_reg[WORD_WIDTH-2:0], serial_in};
        if (!start) begin
            state_nxt   = IDLE;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
        end else begin
            state_nxt = SHIFT;
            if (bit_cnt == BCW'(WORD_WIDTH - 1)) begin
                push        = 1'b1;
                shift_nxt   = '0;
                bit_cnt_nxt = '0;
            end else begin
                shift_nxt   = push_word;
                bit_cnt_nxt = bit_cnt + BCW'(1);
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign data_valid = (fifo_cnt != '0);
    assign data_out   = mem[rd_ptr];
    assign full       = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign pop        = data_valid && data_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push_ok    = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PW'(1);
                if (word_count != {CNT_WIDTH{1'b1}})
                    word_count <= word_count + CNT_WIDTH'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                fifo_cnt <= fifo_cnt + (PW+1)'(1);
            else if (!push_ok && pop)
                fifo_cnt <= fifo_cnt - (PW+1)'(1);
            if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: framing, FIFO full/overflow, abort,
// asynchronous reset and counter saturation (second instance, CNT_WIDTH=4).
module tb_deserializer;

    logic        clk, reset, start, serial_in, data_ready;
    logic [7:0]  data_out, data_out4;
    logic        data_valid, data_valid4;
    logic        overflow, overflow4;
    logic [15:0] word_count;
    logic [3:0]  word_count4;
    logic        busy, busy4;

    int errors = 0;
    int checks = 0;

    deserializer dut (
        .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .overflow(overflow), .word_count(word_count), .busy(busy)
    );

    deserializer #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
        .data_out(data_out4), .data_valid(data_valid4), .data_ready(data_ready),
        .overflow(overflow4), .word_count(word_count4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled at negedge after each edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        start     = 1'b1;
        serial_in = b;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        serial_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        start = 1'b0;
        serial_in = 1'b0;
        data_ready = 1'b0;
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        serial_in = 1'b0;
        data_ready = 1'b0;
        #3;
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", word_count, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // back-to-back 0xA5, 0x3C with sink always ready
        data_ready = 1'b1;
        send_word(8'hA5);
        chk("t1_valid_a5", data_valid, 1);
        chk("t1_data_a5", data_out, 8'hA5);
        chk("t1_busy", busy, 1);
        for (int i = 7; i >= 1; i--) begin
            send_bit(logic'((8'h3C >> i) & 1));
            chk("t1_valid_gap", data_valid, 0);
        end
        send_bit(1'b0);
        chk("t1_valid_3c", data_valid, 1);
        chk("t1_data_3c", data_out, 8'h3C);
        idle(1);
        chk("t1_valid_after", data_valid, 0);
        chk("t1_count", word_count, 2);
        chk("t1_overflow", overflow, 0);
        chk("t1_busy_idle", busy, 0);

        // five words into a four-entry FIFO with sink stalled
        do_reset();
        for (int w = 1; w <= 5; w++) send_word(8'(w));
        idle(1);
        chk("t2_overflow", overflow, 1);
        chk("t2_count", word_count, 4);
        data_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            chk("t2_pop_valid", data_valid, 1);
            chk("t2_pop_data", data_out, w);
            tick();
        end
        chk("t2_empty", data_valid, 0);
        chk("t2_overflow_sticky", overflow, 1);

        // full FIFO, last bit of 5th word coincides with a pop
        do_reset();
        for (int w = 1; w <= 4; w++) send_word(8'(w));
        for (int i = 7; i >= 1; i--) send_bit(logic'((8'h05 >> i) & 1));
        data_ready = 1'b1;
        send_bit(1'b1);
        data_ready = 1'b0;
        idle(1);
        chk("t3_overflow", overflow, 0);
        chk("t3_count", word_count, 5);
        data_ready = 1'b1;
        for (int w = 2; w <= 5; w++) begin
            chk("t3_pop_data", data_out, w);
            tick();
        end
        chk("t3_empty", data_valid, 0);

        // aborted partial word then 0xFF
        do_reset();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        chk("t4_busy_partial", busy, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t4_busy_gap", busy, 0);
            chk("t4_valid_gap", data_valid, 0);
        end
        send_word(8'hFF);
        chk("t4_data", data_out, 8'hFF);
        chk("t4_valid", data_valid, 1);
        chk("t4_count", word_count, 1);
        data_ready = 1'b1;
        idle(1);
        chk("t4_drained", data_valid, 0);
        chk("t4_count_final", word_count, 1);

        // asynchronous reset mid-word with two words queued
        do_reset();
        send_word(8'h11);
        send_word(8'h22);
        send_bit(1); send_bit(1); send_bit(0);
        chk("t5_pre_valid", data_valid, 1);
        chk("t5_pre_count", word_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_data", data_out, 0);
        chk("t5_async_valid", data_valid, 0);
        chk("t5_async_count", word_count, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_overflow", overflow, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_word(8'h5A);
        chk("t5_data", data_out, 8'h5A);
        chk("t5_count", word_count, 1);
        data_ready = 1'b1;
        idle(1);
        chk("t5_drained", data_valid, 0);

        // counter saturation on the CNT_WIDTH=4 instance
        do_reset();
        data_ready = 1'b1;
        for (int w = 1; w <= 15; w++) send_word(8'(w));
        chk("t6_count4_at15", word_count4, 15);
        send_word(8'd16);
        send_word(8'd17);
        chk("t6_data4", data_out4, 17);
        idle(1);
        chk("t6_count4_sat", word_count4, 15);
        chk("t6_count16", word_count, 17);
        chk("t6_overflow4", overflow4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
